// File: rtl/mac_pkg.sv
// ============================================================================
// Module      : mac_pkg
// Description : Shared widths, result record and round-robin helper for the
//               MAC array result path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mac_pkg;

    localparam int ACC_W     = 16;
    localparam int N_MACS    = 4;
    localparam int MAC_IDX_W = 2;

    typedef struct packed {
        logic [MAC_IDX_W-1:0] idx;
        logic [ACC_W-1:0]     data;
    } mac_result_t;

    // N_MACS is a power of two, so the natural wrap of the index is mod N_MACS
    function automatic logic [MAC_IDX_W-1:0] rr_next(input logic [MAC_IDX_W-1:0] idx);
        return idx + 1'b1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO with occupancy count; storage clears on reset
//               so the head reads zero until the first write.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_data,
    output logic                       o_empty,
    output logic                       o_full,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_mem[k] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == c_CNT_W'(DEPTH));
    assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/mac_result_drain.sv
// ============================================================================
// Module      : mac_result_drain
// Description : Captures per-MAC results into holding registers, pulses clear
//               back to the MAC, and round-robin drains them into a FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mac_result_drain #(
    parameter int ACC_W  = mac_pkg::ACC_W,
    parameter int N_MACS = mac_pkg::N_MACS,
    parameter int DEPTH  = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic signed [ACC_W-1:0]           acc_in_0,
    input  logic signed [ACC_W-1:0]           acc_in_1,
    input  logic signed [ACC_W-1:0]           acc_in_2,
    input  logic signed [ACC_W-1:0]           acc_in_3,
    input  logic [N_MACS-1:0]                 valid_in,
    output logic [N_MACS-1:0]                 clear_out,
    output logic signed [ACC_W-1:0]           m_data,
    output logic [mac_pkg::MAC_IDX_W-1:0]     m_idx,
    output logic                              m_valid,
    input  logic                              m_ready,
    output logic [$clog2(DEPTH+1)-1:0]        count,
    output logic                              overflow
);

    import mac_pkg::*;

    localparam int c_FIFO_W = MAC_IDX_W + ACC_W;

    logic [ACC_W-1:0]     w_acc   [N_MACS];
    logic [ACC_W-1:0]     r_hold  [N_MACS];
    logic [N_MACS-1:0]    r_pend;
    logic [N_MACS-1:0]    r_clear;
    logic [MAC_IDX_W-1:0] r_rr;
    logic                 r_overflow;

    logic [N_MACS-1:0]    w_freed;
    logic [N_MACS-1:0]    w_capture;
    logic [N_MACS-1:0]    w_drop;
    logic [MAC_IDX_W-1:0] w_scan;
    logic [MAC_IDX_W-1:0] w_grant_idx;
    logic                 w_grant_valid;
    logic                 w_can_accept;
    logic                 w_pop;
    logic                 w_empty;
    logic                 w_full;
    logic [c_FIFO_W-1:0]  w_push_data;
    logic [c_FIFO_W-1:0]  w_head;

    assign w_acc[0] = acc_in_0;
    assign w_acc[1] = acc_in_1;
    assign w_acc[2] = acc_in_2;
    assign w_acc[3] = acc_in_3;

    assign w_pop        = !w_empty && m_ready;
    assign w_can_accept = !w_full || w_pop;

    // Scan downward so the channel closest to r_rr is the last (winning) write
    always_comb begin
        w_grant_valid = 1'b0;
        w_grant_idx   = '0;
        w_scan        = '0;
        if (w_can_accept) begin
            for (int k = N_MACS - 1; k >= 0; k--) begin
                w_scan = r_rr + MAC_IDX_W'(k);
                if (r_pend[w_scan]) begin
                    w_grant_valid = 1'b1;
                    w_grant_idx   = w_scan;
                end
            end
        end
    end

    // A slot emptied by this cycle's grant may take a new result immediately
    generate
        for (genvar gi = 0; gi < N_MACS; gi++) begin : g_chan
            assign w_freed[gi]   = w_grant_valid && (w_grant_idx == MAC_IDX_W'(gi));
            assign w_capture[gi] = valid_in[gi] && (!r_pend[gi] || w_freed[gi]);
            assign w_drop[gi]    = valid_in[gi] && r_pend[gi] && !w_freed[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_MACS; i++) begin
                r_hold[i] <= '0;
            end
            r_pend     <= '0;
            r_clear    <= '0;
            r_rr       <= '0;
            r_overflow <= 1'b0;
        end else begin
            for (int i = 0; i < N_MACS; i++) begin
                if (w_capture[i]) begin
                    r_hold[i] <= w_acc[i];
                    r_pend[i] <= 1'b1;
                end else if (w_freed[i]) begin
                    r_pend[i] <= 1'b0;
                end
            end
            r_clear    <= w_capture;
            r_overflow <= r_overflow | (|w_drop);
            if (w_grant_valid) begin
                r_rr <= rr_next(w_grant_idx);
            end
        end
    end

    assign w_push_data = {w_grant_idx, r_hold[w_grant_idx]};

    sync_fifo #(
        .WIDTH (c_FIFO_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_grant_valid),
        .i_data  (w_push_data),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_empty (w_empty),
        .o_full  (w_full),
        .o_count (count)
    );

    assign m_valid   = !w_empty;
    assign m_data    = w_head[ACC_W-1:0];
    assign m_idx     = w_head[c_FIFO_W-1 -: MAC_IDX_W];
    assign clear_out = r_clear;
    assign overflow  = r_overflow;

endmodule

`default_nettype wire
